// File: rtl/txn_out_arbiter.sv
// Packet-atomic two-source AXI-Stream arbiter: a source is locked one cycle after it shows valid, data appears two cycles after that valid, with one IDLE bubble between packets.
// Backpressure: m_tready feeds s*_tready combinationally through the single output slice; MMIO may win only STARVE_LIMIT times in a row while DMA waits.
module txn_out_arbiter #(
    parameter int DATA_BITS    = 512,
    parameter int KEEP_WIDTH   = DATA_BITS / 8,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,

    input  logic [DATA_BITS-1:0]  s0_tdata,
    input  logic [KEEP_WIDTH-1:0] s0_tkeep,
    input  logic                  s0_tlast,
    input  logic                  s0_tuser,
    input  logic                  s0_tvalid,
    output logic                  s0_tready,

    input  logic [DATA_BITS-1:0]  s1_tdata,
    input  logic [KEEP_WIDTH-1:0] s1_tkeep,
    input  logic                  s1_tlast,
    input  logic                  s1_tuser,
    input  logic                  s1_tvalid,
    output logic                  s1_tready,

    output logic [DATA_BITS-1:0]  m_tdata,
    output logic [KEEP_WIDTH-1:0] m_tkeep,
    output logic                  m_tlast,
    output logic                  m_tuser,
    output logic                  m_tvalid,
    input  logic                  m_tready,

    output logic                  grant_mmio,
    output logic                  grant_dma,
    output logic [CNT_WIDTH-1:0]  mmio_pkt_cnt,
    output logic [CNT_WIDTH-1:0]  dma_pkt_cnt
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_BITS-1:0]  tdata;
        logic [KEEP_WIDTH-1:0] tkeep;
        logic                  tlast;
        logic                  tuser;
    } beat_t;

    state_t          state;
    state_t          state_nxt;
    logic [SW-1:0]   streak;
    beat_t           out_beat;
    beat_t           in_beat;
    logic            slot_free;
    logic            acc0;
    logic            acc1;
    logic            acc;

    assign slot_free = ~m_tvalid | m_tready;
    assign acc0      = s0_tvalid & s0_tready;
    assign acc1      = s1_tvalid & s1_tready;
    assign acc       = acc0 | acc1;

    // State register
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (s0_tvalid && s1_tvalid) begin
                    state_nxt = (streak >= LIMIT) ? LOCK1 : LOCK0;
                end else if (s0_tvalid) begin
                    state_nxt = LOCK0;
                end else if (s1_tvalid) begin
                    state_nxt = LOCK1;
                end
            end
            LOCK0:   if (acc0 && s0_tlast) state_nxt = IDLE;
            LOCK1:   if (acc1 && s1_tlast) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        s0_tready  = (state == LOCK0) & slot_free;
        s1_tready  = (state == LOCK1) & slot_free;
        grant_mmio = (state == LOCK0);
        grant_dma  = (state == LOCK1);
        in_beat    = acc1 ? beat_t'{s1_tdata, s1_tkeep, s1_tlast, s1_tuser}
                          : beat_t'{s0_tdata, s0_tkeep, s0_tlast, s0_tuser};
    end

    // Only MMIO wins taken while DMA was also waiting count towards starvation
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            streak <= '0;
        end else if (state == IDLE) begin
            if (state_nxt == LOCK1) begin
                streak <= '0;
            end else if (state_nxt == LOCK0 && s1_tvalid && streak < LIMIT) begin
                streak <= streak + SW'(1);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            out_beat <= '0;
            m_tvalid <= 1'b0;
        end else if (acc) begin
            out_beat <= in_beat;
            m_tvalid <= 1'b1;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

    assign m_tdata = out_beat.tdata;
    assign m_tkeep = out_beat.tkeep;
    assign m_tlast = out_beat.tlast;
    assign m_tuser = out_beat.tuser;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            mmio_pkt_cnt <= '0;
            dma_pkt_cnt  <= '0;
        end else begin
            if (acc0 && s0_tlast) mmio_pkt_cnt <= mmio_pkt_cnt + CNT_WIDTH'(1);
            if (acc1 && s1_tlast) dma_pkt_cnt  <= dma_pkt_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_txn_out_arbiter.sv
// Directed bench for txn_out_arbiter: cycle table for the basic flows, then starvation, backpressure, reset and wrap sequences.
module tb_txn_out_arbiter;

    localparam int DW = 32;
    localparam int KW = DW / 8;
    localparam int CW = 4;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [DW-1:0] s0_tdata, s1_tdata, m_tdata;
    logic [KW-1:0] s0_tkeep, s1_tkeep, m_tkeep;
    logic          s0_tlast, s0_tuser, s0_tvalid, s0_tready;
    logic          s1_tlast, s1_tuser, s1_tvalid, s1_tready;
    logic          m_tlast, m_tuser, m_tvalid, m_tready;
    logic          grant_mmio, grant_dma;
    logic [CW-1:0] mmio_pkt_cnt, dma_pkt_cnt;

    int total = 0;
    int bad   = 0;

    txn_out_arbiter #(
        .DATA_BITS(DW), .KEEP_WIDTH(KW), .STARVE_LIMIT(4), .CNT_WIDTH(CW)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s0_tdata(s0_tdata), .s0_tkeep(s0_tkeep), .s0_tlast(s0_tlast), .s0_tuser(s0_tuser),
        .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
        .s1_tdata(s1_tdata), .s1_tkeep(s1_tkeep), .s1_tlast(s1_tlast), .s1_tuser(s1_tuser),
        .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tuser(m_tuser),
        .m_tvalid(m_tvalid), .m_tready(m_tready),
        .grant_mmio(grant_mmio), .grant_dma(grant_dma),
        .mmio_pkt_cnt(mmio_pkt_cnt), .dma_pkt_cnt(dma_pkt_cnt)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic        s0v, s0l;
        logic [31:0] s0d;
        logic        s1v, s1l;
        logic [31:0] s1d;
        logic        mr;
        logic        emv;
        logic [31:0] emd;
        logic        eml, esrc;
        logic        es0r, es1r, egm, egd;
        int          emc, edc;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to 1 time unit after the next rising edge, where inputs are driven
    task automatic next_cycle();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_inputs();
        s0_tvalid = 1'b0; s0_tlast = 1'b0; s0_tdata = '0;
        s1_tvalid = 1'b0; s1_tlast = 1'b0; s1_tdata = '0;
    endtask

    task automatic send_s0(input logic [31:0] dat);
        bit done = 1'b0;
        s0_tvalid = 1'b1; s0_tlast = 1'b1; s0_tdata = dat;
        for (int c = 0; c < 20 && !done; c++) begin
            #3;
            done = s0_tvalid & s0_tready;
            next_cycle();
        end
        s0_tvalid = 1'b0;
        if (!done) chk("send_s0_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset(input int cycles);
        idle_inputs();
        m_tready = 1'b1;
        aresetn  = 1'b0;
        repeat (cycles) next_cycle();
        aresetn = 1'b1;
    endtask

    initial begin
        s0_tkeep = 4'hF; s0_tuser = 1'b1;
        s1_tkeep = 4'h3; s1_tuser = 1'b0;
        #1;
        do_reset(3);
        // Still inside the same cycle as release: registered outputs hold reset values
        #3;
        chk("rst_m_tvalid", 32'(m_tvalid), 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_m_tlast", 32'(m_tlast), 0);
        chk("rst_grant_mmio", 32'(grant_mmio), 0);
        chk("rst_grant_dma", 32'(grant_dma), 0);
        chk("rst_mmio_cnt", 32'(mmio_pkt_cnt), 0);
        chk("rst_dma_cnt", 32'(dma_pkt_cnt), 0);
        next_cycle();

        // s0v s0l s0d      s1v s1l s1d     mr  emv emd      eml src s0r s1r gm gd mc dc
        vecs[0]  = '{1,1,32'h1234, 0,0,32'h0,  1,  0,32'h0,    0,0, 0,0,0,0, 0,0};
        vecs[1]  = '{1,1,32'h1234, 0,0,32'h0,  1,  0,32'h0,    0,0, 1,0,1,0, 0,0};
        vecs[2]  = '{0,0,32'h0,    0,0,32'h0,  1,  1,32'h1234, 1,0, 0,0,0,0, 1,0};
        vecs[3]  = '{0,0,32'h0,    0,0,32'h0,  1,  0,32'h0,    0,0, 0,0,0,0, 1,0};
        vecs[4]  = '{0,0,32'h0,    1,0,32'hA0, 1,  0,32'h0,    0,0, 0,0,0,0, 1,0};
        vecs[5]  = '{0,0,32'h0,    1,0,32'hA0, 1,  0,32'h0,    0,0, 0,1,0,1, 1,0};
        vecs[6]  = '{1,1,32'h55,   1,0,32'hA1, 1,  1,32'hA0,   0,1, 0,1,0,1, 1,0};
        vecs[7]  = '{1,1,32'h55,   1,0,32'hA2, 1,  1,32'hA1,   0,1, 0,1,0,1, 1,0};
        vecs[8]  = '{1,1,32'h55,   1,1,32'hA3, 1,  1,32'hA2,   0,1, 0,1,0,1, 1,0};
        vecs[9]  = '{1,1,32'h55,   0,0,32'h0,  1,  1,32'hA3,   1,1, 0,0,0,0, 1,1};
        vecs[10] = '{1,1,32'h55,   0,0,32'h0,  1,  0,32'h0,    0,0, 1,0,1,0, 1,1};
        vecs[11] = '{0,0,32'h0,    0,0,32'h0,  1,  1,32'h55,   1,0, 0,0,0,0, 2,1};
        vecs[12] = '{1,1,32'h66,   0,0,32'h0,  0,  0,32'h0,    0,0, 0,0,0,0, 2,1};
        vecs[13] = '{1,1,32'h66,   0,0,32'h0,  0,  0,32'h0,    0,0, 1,0,1,0, 2,1};
        vecs[14] = '{0,0,32'h0,    0,0,32'h0,  0,  1,32'h66,   1,0, 0,0,0,0, 3,1};
        vecs[15] = '{1,1,32'h77,   0,0,32'h0,  0,  1,32'h66,   1,0, 0,0,0,0, 3,1};
        vecs[16] = '{1,1,32'h77,   0,0,32'h0,  0,  1,32'h66,   1,0, 0,0,1,0, 3,1};
        vecs[17] = '{1,1,32'h77,   0,0,32'h0,  1,  1,32'h66,   1,0, 1,0,1,0, 3,1};
        vecs[18] = '{0,0,32'h0,    0,0,32'h0,  1,  1,32'h77,   1,0, 0,0,0,0, 4,1};

        for (int i = 0; i < NV; i++) begin
            s0_tvalid = vecs[i].s0v; s0_tlast = vecs[i].s0l; s0_tdata = vecs[i].s0d;
            s1_tvalid = vecs[i].s1v; s1_tlast = vecs[i].s1l; s1_tdata = vecs[i].s1d;
            m_tready  = vecs[i].mr;
            #3;
            chk($sformatf("v%0d_m_tvalid", i), 32'(m_tvalid), 32'(vecs[i].emv));
            if (vecs[i].emv) begin
                chk($sformatf("v%0d_m_tdata", i), m_tdata, vecs[i].emd);
                chk($sformatf("v%0d_m_tlast", i), 32'(m_tlast), 32'(vecs[i].eml));
                chk($sformatf("v%0d_m_tkeep", i), 32'(m_tkeep), vecs[i].esrc ? 32'h3 : 32'hF);
                chk($sformatf("v%0d_m_tuser", i), 32'(m_tuser), vecs[i].esrc ? 32'h0 : 32'h1);
            end
            chk($sformatf("v%0d_s0_tready", i), 32'(s0_tready), 32'(vecs[i].es0r));
            chk($sformatf("v%0d_s1_tready", i), 32'(s1_tready), 32'(vecs[i].es1r));
            chk($sformatf("v%0d_grant_mmio", i), 32'(grant_mmio), 32'(vecs[i].egm));
            chk($sformatf("v%0d_grant_dma", i), 32'(grant_dma), 32'(vecs[i].egd));
            chk($sformatf("v%0d_mmio_cnt", i), 32'(mmio_pkt_cnt), 32'(vecs[i].emc));
            chk($sformatf("v%0d_dma_cnt", i), 32'(dma_pkt_cnt), 32'(vecs[i].edc));
            next_cycle();
        end
        idle_inputs();
        m_tready = 1'b1;
        next_cycle();

        // Starvation: both sources always valid with single-beat packets
        begin
            logic rec[10];
            logic exp_src[10];
            int   nrec = 0;
            int   nacc = 0;
            exp_src = '{0,0,0,0,1,0,0,0,0,1};
            for (int c = 0; c < 80 && nrec < 10; c++) begin
                if (nacc < 10) begin
                    s0_tvalid = 1'b1; s0_tlast = 1'b1; s0_tdata = 32'h100;
                    s1_tvalid = 1'b1; s1_tlast = 1'b1; s1_tdata = 32'h200;
                end else begin
                    idle_inputs();
                end
                #3;
                if ((s0_tvalid && s0_tready) || (s1_tvalid && s1_tready)) nacc++;
                if (m_tvalid) begin
                    rec[nrec] = m_tdata[9];
                    nrec++;
                end
                next_cycle();
            end
            idle_inputs();
            chk("starve_count", nrec, 10);
            for (int k = 0; k < 10 && k < nrec; k++)
                chk($sformatf("starve_src%0d", k), 32'(rec[k]), 32'(exp_src[k]));
            repeat (2) next_cycle();
            chk("starve_mmio_cnt", 32'(mmio_pkt_cnt), 32'd12);
            chk("starve_dma_cnt", 32'(dma_pkt_cnt), 32'd3);
        end

        // Backpressure: 16-beat s1 packet, random m_tready
        begin
            int   idx = 0;
            int   exp_out = 0;
            logic hold = 1'b0;
            logic [31:0] held_dat = '0;
            logic        held_last = 1'b0;
            for (int c = 0; c < 300 && exp_out < 16; c++) begin
                m_tready  = 1'($urandom_range(0, 1));
                s1_tvalid = (idx < 16);
                s1_tdata  = 32'(idx);
                s1_tlast  = (idx == 15);
                #3;
                if (hold) begin
                    chk("bp_hold_vld", 32'(m_tvalid), 1);
                    chk("bp_hold_dat", m_tdata, held_dat);
                    chk("bp_hold_last", 32'(m_tlast), 32'(held_last));
                end
                if (m_tvalid && m_tready) begin
                    chk("bp_data", m_tdata, 32'(exp_out));
                    chk("bp_last", 32'(m_tlast), 32'(exp_out == 15));
                    exp_out++;
                end
                hold      = m_tvalid & ~m_tready;
                held_dat  = m_tdata;
                held_last = m_tlast;
                if (s1_tvalid && s1_tready) idx++;
                next_cycle();
            end
            idle_inputs();
            m_tready = 1'b1;
            chk("bp_beats", exp_out, 16);
            next_cycle();
            chk("bp_dma_cnt", 32'(dma_pkt_cnt), 32'd4);
        end

        // Reset while beat 3 of an 8-beat s1 packet is on the input
        begin
            int idx = 0;
            for (int c = 0; c < 40 && idx < 3; c++) begin
                s1_tvalid = 1'b1; s1_tdata = 32'h300 + 32'(idx); s1_tlast = 1'b0;
                #3;
                if (s1_tvalid && s1_tready) idx++;
                next_cycle();
            end
            chk("rmp_reached_beat3", idx, 3);
            s1_tdata = 32'h303;
            aresetn  = 1'b0;
            next_cycle();
            aresetn = 1'b1;
            idle_inputs();
            #3;
            chk("rmp_m_tvalid", 32'(m_tvalid), 0);
            chk("rmp_grant_dma", 32'(grant_dma), 0);
            chk("rmp_mmio_cnt", 32'(mmio_pkt_cnt), 0);
            chk("rmp_dma_cnt", 32'(dma_pkt_cnt), 0);
            chk("rmp_s1_tready", 32'(s1_tready), 0);
            next_cycle();
            send_s0(32'h0ABC);
            #3;
            chk("rmp_s0_m_tvalid", 32'(m_tvalid), 1);
            chk("rmp_s0_m_tdata", m_tdata, 32'h0ABC);
            chk("rmp_s0_mmio_cnt", 32'(mmio_pkt_cnt), 1);
            next_cycle();
        end

        // Counter wrap: 17 single-beat packets on a 4-bit counter
        do_reset(2);
        for (int p = 0; p < 17; p++) begin
            send_s0(32'h500 + 32'(p));
            if (p == 15) begin
                #3;
                chk("wrap_cnt_16", 32'(mmio_pkt_cnt), 0);
                next_cycle();
            end
        end
        #3;
        chk("wrap_cnt_17", 32'(mmio_pkt_cnt), 1);
        chk("wrap_dma_cnt", 32'(dma_pkt_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time bound, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/txn_out_arbiter.md
# txn_out_arbiter

Packet-atomic arbiter that shares the single outgoing AXI-Stream of the transaction generator between two sources. Source 0 carries MMIO read responses; source 1 carries the DMA request/payload stream. The block replaces the ad-hoc mutual-exclusion gating between the MMIO and DMA paths with one grant state machine and one registered output slice. It guarantees that a packet is never interleaved with another and that DMA is never starved by MMIO traffic.

## Interface
- DATA_BITS, 512, tdata width of all streams
- KEEP_WIDTH, DATA_BITS/8, tkeep width
- STARVE_LIMIT, 4, max consecutive MMIO grants while DMA waits (≥1)
- CNT_WIDTH, 32, width of packet counters

- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- s0_tdata / s0_tkeep / s0_tlast / s0_tuser  in  DATA_BITS / KEEP_WIDTH / 1 / 1  MMIO response stream
- s0_tvalid  in  1;  s0_tready  out  1
- s1_tdata / s1_tkeep / s1_tlast / s1_tuser  in  DATA_BITS / KEEP_WIDTH / 1 / 1  DMA stream
- s1_tvalid  in  1;  s1_tready  out  1
- m_tdata / m_tkeep / m_tlast / m_tuser  out  DATA_BITS / KEEP_WIDTH / 1 / 1  merged output
- m_tvalid  out  1;  m_tready  in  1
- grant_mmio  out  1  state == LOCK0
- grant_dma  out  1  state == LOCK1
- mmio_pkt_cnt  out  CNT_WIDTH  packets accepted from s0
- dma_pkt_cnt  out  CNT_WIDTH  packets accepted from s1

## Operation
- **States:** IDLE, LOCK0, LOCK1. Registered. Reset to IDLE.
- **IDLE:** both s*_tready = 0. The arbitration decision is taken this cycle and applied at the next edge.
  - Only s0_tvalid → LOCK0.
  - Only s1_tvalid → LOCK1.
  - Both valid → LOCK1 if streak ≥ STARVE_LIMIT, else LOCK0.
  - Neither valid → stay in IDLE.
- **Streak counter:** width clog2(STARVE_LIMIT+1).
  - Increments, saturating at STARVE_LIMIT, when IDLE→LOCK0 occurs with s1_tvalid = 1.
  - Clears to 0 on IDLE→LOCK1.
  - Unchanged otherwise.
- **LOCKx:** sx_tready = slot_free, where slot_free = ~m_tvalid | m_tready. The other source's tready = 0.
  - An accepted beat (sx_tvalid & sx_tready) loads the output register.
  - An accepted beat with sx_tlast = 1 → IDLE, and the matching pkt_cnt increments (wraps modulo 2^CNT_WIDTH).
- **Output register:**
  - Loads tdata/tkeep/tlast/tuser on an accepted beat and sets m_tvalid.
  - Otherwise, m_tvalid clears on m_tready.
  - While m_tvalid & ~m_tready, all m_* stay stable.
- **Packets:** a packet is never split. While locked, the other source waits regardless of its valid. No length limit; the lock is released only by tlast.
- **Single-beat packets** (tlast on first beat) are legal on either source.
- **Reset values:** state IDLE; streak 0; m_tvalid 0; m_tdata/m_tkeep/m_tlast/m_tuser 0; s0_tready/s1_tready 0; grant_* 0; both counters 0.
- **Reset mid-packet:** lock dropped, output register emptied, counters cleared. Upstream sources share aresetn and restart on packet boundaries.

## Timing
- **Arbitration latency:** a source valid in IDLE at cycle t is locked at t+1. Its first beat is accepted in t+1 if the slot is free, and m_tvalid is high from t+2.
- **Throughput:** while locked, one beat per cycle with m_tready held at 1 (the register drains and refills in the same cycle).
- **Inter-packet gap:** exactly one IDLE cycle after each tlast acceptance, i.e. one bubble on the input side. The output may still be draining the last beat during that cycle.
- **Backpressure:** m_tready low → slot_free low → sx_tready low in the same cycle (combinational path m_tready → sx_tready). No beat is dropped or duplicated.
- grant_mmio and grant_dma are registered and never high simultaneously.
- pkt_cnt updates one cycle after the tlast handshake edge.

## Test plan
- **MMIO only:** a 1-beat s0 packet with tdata = 0x…_1234 and m_tready = 1 → m_tvalid at t+2 with the same data, m_tlast = 1, mmio_pkt_cnt = 1; s1_tready stays 0 throughout.
- **DMA multi-beat under contention:** s1 sends a 4-beat packet; s0 raises valid after beat 1 → all 4 s1 beats appear contiguously on m_*, then one IDLE cycle, then the s0 beat; dma_pkt_cnt = 1, mmio_pkt_cnt = 1.
- **Starvation limit:** STARVE_LIMIT = 4, both sources continuously valid with 1-beat packets → output source order 0,0,0,0,1,0,0,0,0,1…; streak returns to 0 after each DMA grant.
- **Backpressure:** random m_tready at 50 % duty during a 16-beat s1 packet with incrementing tdata → output sequence 0..15 with no gaps or duplicates, and m_* stable whenever m_tvalid & ~m_tready.
- **Reset mid-packet:** aresetn low for 1 cycle during beat 3 of an 8-beat s1 packet → next cycle m_tvalid = 0, grant_dma = 0, counters = 0; a fresh s0 packet afterwards is granted normally.
- **Counter wrap:** CNT_WIDTH = 4, send 17 single-beat s0 packets → mmio_pkt_cnt = 1.
